// File: rtl/store_writer.sv
// rtl/store_writer.sv - store formatter and in-order write buffer onto an Avalon-style data-memory port
//
// Accepts sb/sh/sw requests, places the data on the right byte lanes with
// matching byte-enables, and queues each formatted write.
// The buffer head drives the memory write port.
// Optional feature macro: STORE_ALIGN_CHECK_EN
//   When defined, misaligned sh/sw are accepted, dropped, and flagged for one cycle.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   st_valid/st_ready     store request handshake
//   st_size               1=sb, 2=sh, 3=sw, 0=reserved (accepted and dropped)
//   st_addr, st_data      byte address and register data
//   mem_address           word-aligned head address (zero when empty)
//   mem_write             head valid
//   mem_writedata         lane-aligned head data (zero when empty)
//   mem_byteenable        head lane enables (zero when empty)
//   mem_waitrequest       slave stall
//   busy                  buffer non-empty
//   st_misaligned         one-cycle misaligned-store pulse (0 without the macro)
module store_writer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic [31:0] mem_address,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic        mem_waitrequest,
  output logic        busy,
  output logic        st_misaligned
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [29:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [3:0]    be_q   [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [31:0] fmt_data;
  logic [3:0]  fmt_be;
  logic        mis;
  logic        accept;
  logic        enq;
  logic        deq;

  // Lane formatting happens at enqueue so the head entry is bus-ready.
  always_comb begin
    fmt_data = st_data;
    fmt_be   = 4'b0000;
    case (st_size)
      2'd1: begin
        fmt_data = {4{st_data[7:0]}};
        case (st_addr[1:0])
          2'd0:    fmt_be = 4'b0001;
          2'd1:    fmt_be = 4'b0010;
          2'd2:    fmt_be = 4'b0100;
          default: fmt_be = 4'b1000;
        endcase
      end
      2'd2: begin
        fmt_data = {2{st_data[15:0]}};
        fmt_be   = st_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'd3: begin
        fmt_data = st_data;
        fmt_be   = 4'b1111;
      end
      default: begin
        fmt_data = st_data;
        fmt_be   = 4'b0000;
      end
    endcase
  end

`ifdef STORE_ALIGN_CHECK_EN
  assign mis = ((st_size == 2'd2) && st_addr[0]) ||
               ((st_size == 2'd3) && (st_addr[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  // No pass-through when full: a same-cycle retire does not open a slot.
  assign st_ready = (count != CW'(DEPTH));
  assign accept   = st_valid && st_ready;
  assign enq      = accept && (st_size != 2'd0) && !mis;
  assign mem_write = (count != '0);
  assign deq      = mem_write && !mem_waitrequest;
  assign busy     = mem_write;

  assign mem_address    = mem_write ? {addr_q[rd_ptr], 2'b00} : 32'h0;
  assign mem_writedata  = mem_write ? data_q[rd_ptr] : 32'h0;
  assign mem_byteenable = mem_write ? be_q[rd_ptr] : 4'b0000;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
      end
    end else begin
      if (enq) begin
        addr_q[wr_ptr] <= st_addr[31:2];
        data_q[wr_ptr] <= fmt_data;
        be_q[wr_ptr]   <= fmt_be;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef STORE_ALIGN_CHECK_EN
  logic mis_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= accept && mis;
    end
  end
  assign st_misaligned = mis_q;
`else
  assign st_misaligned = 1'b0;
`endif

endmodule

// File: doc/store_writer.md
# store_writer

Store-path counterpart of the load-data selector: accepts store requests (sb, sh, sw) from the CPU datapath and aligns the register data onto the correct byte lanes. Generates the matching byte-enables and queues each formatted write in a small in-order buffer. Drains the buffer onto the Avalon-style data-memory write port, honouring `mem_waitrequest`. Sits between the ALU/register-file outputs and the data-memory bus; `busy` lets control stall loads until all stores have drained.

## Interface
- `DEPTH`, 2, store-buffer entries; power of two, ≥2.
- `clk`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `st_valid`  in  1  store request present.
- `st_ready`  out  1  buffer can accept; transfer occurs when `st_valid && st_ready`.
- `st_size`  in  2  1=sb, 2=sh, 3=sw, 0=reserved.
- `st_addr`  in  32  byte address (ALU result).
- `st_data`  in  32  rt value; the low byte or halfword is used for sb/sh.
- `mem_address`  out  32  word-aligned address of the buffer head.
- `mem_write`  out  1  buffer head valid.
- `mem_writedata`  out  32  lane-aligned data.
- `mem_byteenable`  out  4  active lanes.
- `mem_waitrequest`  in  1  slave stall.
- `busy`  out  1  buffer non-empty.
- `st_misaligned`  out  1  misaligned-store flag (see Configuration).

## Operation
- Formatting is done at enqueue. Entries store {word address, data, byteenable}.
- sb: data = byte replicated ×4. Byteenable = one-hot at `st_addr[1:0]` (00→0001, 11→1000).
- sh: data = {half, half}. Byteenable = 0011 when `st_addr[1]`=0, else 1100.
- sw: data = `st_data`, byteenable = 1111.
- `mem_address` = {`st_addr[31:2]`, 2'b00}.
- `st_size`=0: request is accepted and dropped; no write, no flag.
- FIFO is circular, using read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of 0..DEPTH.
- `st_ready` = (count != DEPTH). There is no pass-through when full, even if the head retires in the same cycle.
- `mem_write` = (count != 0). `mem_*` are driven from the head entry; they are all-zero when empty.
- Head retires on any cycle with `mem_write && !mem_waitrequest`.
- Enqueue and retire in the same cycle: count unchanged, both pointers advance.
- Strict program order; no write merging.
- `busy` = (count != 0).

## Timing
- Reset values: count=0, pointers=0, `mem_write`=0, `mem_address`/`mem_writedata`/`mem_byteenable`=0, `busy`=0, `st_misaligned`=0, `st_ready`=1.
- Reset assertion mid-transfer discards all entries. `mem_write` drops asynchronously and the slave sees the write abandoned.
- Latency: a request accepted at edge N appears on `mem_*` after edge N (registered), i.e. earliest bus cycle N+1. With waitrequest low it retires at edge N+1.
- While `mem_waitrequest`=1, `mem_address`/`mem_writedata`/`mem_byteenable` are held stable.
- Throughput with zero wait states is one store per cycle.

## Configuration
- `STORE_ALIGN_CHECK_EN` defined:
  - A misaligned request is sh with `st_addr[0]`=1, or sw with `st_addr[1:0]`≠0.
  - It is accepted (handshake completes) but not enqueued.
  - `st_misaligned` pulses high for exactly one cycle, the cycle after acceptance.
- `STORE_ALIGN_CHECK_EN` undefined:
  - No check. sh uses only `st_addr[1]`; sw ignores `st_addr[1:0]`.
  - `st_misaligned` is tied to 0.

## Test plan
- sb, addr 0x00001003, data 0x000000AB, waitrequest=0 → next cycle: `mem_write`=1 for one cycle, address 0x00001000, writedata 0xABABABAB, byteenable 1000.
- sh, addr 0x00002002, data 0x1234BEEF → writedata 0xBEEFBEEF, byteenable 1100. The same request at 0x00002000 → byteenable 0011.
- DEPTH=2, waitrequest held 1, three back-to-back sw (0x10,0x14,0x18):
  - `st_ready` falls after two are accepted; the third is held with `mem_*` stable.
  - After waitrequest drops, writes appear in order 0x10, 0x14, 0x18; `busy` falls the cycle after the last retires.
- count=1, enqueue and retire in the same cycle → count stays 1 and the new entry becomes head. Repeat the pattern for 5 cycles to exercise pointer wrap with no reordering.
- sw at 0x00003001 with `STORE_ALIGN_CHECK_EN` → no `mem_write`, one-cycle `st_misaligned`. Without the macro → write to 0x00003000, byteenable 1111.
- Two entries pending and waitrequest=1, `reset` pulsed low → `mem_write` falls immediately. After release: `busy`=0, `st_ready`=1, and no stale write is issued.
